// File: rtl/mxv_fetch_scheduler_pkg.sv
// Shared types and constants for the mXv fetch scheduler.
package mxv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned MEM_AW = 32;
  localparam logic [MEM_AW-1:0] ADDR_INIT = '1;

  localparam int unsigned ERR_W            = 2;
  localparam int unsigned ERR_OVERRUN      = 0;
  localparam int unsigned ERR_EARLY_FINISH = 1;

endpackage

// File: rtl/mxv_fetch_scheduler_if.sv
// Bundles the controller-side and core-side signals of the fetch scheduler.
interface mxv_fetch_scheduler_if #(
  parameter int unsigned EW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned NU = 8
);
  localparam int unsigned RES_W = NU * EW;
  localparam int unsigned CNT_W = 32;

  logic             i_start;
  logic [CNT_W-1:0] i_total_with_additional_A;
  logic             i_memories_pre_preprocess;
  logic             i_mXv1_finish;
  logic             i_outsider_read_now;
  logic [RES_W-1:0] i_mXv1_result;

  logic             o_reset_mXv1;
  logic [AW-1:0]    o_memoryA_read_address;
  logic [AW-1:0]    o_col_nos_read_address;
  logic [AW-1:0]    o_multiples_read_address;
  logic             o_memories_preprocess;
  logic [RES_W-1:0] o_result_data;
  logic             o_result_valid;
  logic [CNT_W-1:0] o_result_count;
  logic             o_busy;
  logic             o_done;
  logic [1:0]       o_error;

  modport master (
    input  i_start, i_total_with_additional_A, i_memories_pre_preprocess,
           i_mXv1_finish, i_outsider_read_now, i_mXv1_result,
    output o_reset_mXv1, o_memoryA_read_address, o_col_nos_read_address,
           o_multiples_read_address, o_memories_preprocess, o_result_data,
           o_result_valid, o_result_count, o_busy, o_done, o_error
  );

  modport slave (
    output i_start, i_total_with_additional_A, i_memories_pre_preprocess,
           i_mXv1_finish, i_outsider_read_now, i_mXv1_result,
    input  o_reset_mXv1, o_memoryA_read_address, o_col_nos_read_address,
           o_multiples_read_address, o_memories_preprocess, o_result_data,
           o_result_valid, o_result_count, o_busy, o_done, o_error
  );
endinterface

// File: rtl/mxv_fetch_scheduler_addr_counter.sv
// Shared operand-memory read address: loads all-ones, increments, wraps.
module mxv_addr_counter #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_inc,
  output logic [AW-1:0] o_addr
);

  logic [AW-1:0] r_addr;

  // Load has priority so a new pass always restarts from all-ones.
  always_ff @(posedge clk) begin
    if (reset || i_load) begin
      r_addr <= '1;
    end else if (i_inc) begin
      r_addr <= r_addr + AW'(1);
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/mxv_fetch_scheduler.sv
// Sequences one matrix-by-vector pass: address fetch, core enable, result
// capture and completion/error reporting.
module mxv_fetch_scheduler
  import mxv_sched_pkg::*;
#(
  parameter int unsigned element_width               = 32,
  parameter int unsigned memories_address_width      = 32,
  parameter int unsigned no_of_row_by_vector_modules = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mxv_fetch_scheduler_if.master bus
);

  localparam int unsigned AW    = memories_address_width;
  localparam int unsigned NU    = 2 * no_of_row_by_vector_modules;
  localparam int unsigned RES_W = NU * element_width;
  localparam int unsigned CNT_W = 32;

  state_t           r_state;
  state_t           w_next_state;

  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_result_count;
  logic [RES_W-1:0] r_result_data;
  logic             r_result_valid;
  logic             r_memories_preprocess;
  logic             r_reset_mxv;
  logic             r_busy;
  logic             r_done;
  logic [ERR_W-1:0] r_error;

  logic             w_start;
  logic             w_accept;
  logic             w_capture;
  logic             w_below;
  logic             w_last;
  logic             w_err_overrun;
  logic             w_err_early;
  logic [AW-1:0]    w_addr;

  assign w_below = r_issued < r_total;
  assign w_last  = (r_issued + CNT_W'(1)) == r_total;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_start       = 1'b0;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_err_overrun = 1'b0;
    w_err_early   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_start      = 1'b1;
          w_next_state = (bus.i_total_with_additional_A == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_accept  = bus.i_memories_pre_preprocess && w_below;
        w_capture = bus.i_outsider_read_now;
        if (bus.i_mXv1_finish) begin
          w_next_state = DONE;
          w_err_early  = w_below;
        end else if (!w_below || (w_accept && w_last)) begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        w_capture     = bus.i_outsider_read_now;
        w_err_overrun = bus.i_memories_pre_preprocess;
        if (bus.i_mXv1_finish) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Status strobes are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_total               <= '0;
      r_issued              <= '0;
      r_result_count        <= '0;
      r_result_data         <= '0;
      r_result_valid        <= 1'b0;
      r_memories_preprocess <= 1'b0;
      r_reset_mxv           <= 1'b0;
      r_busy                <= 1'b0;
      r_done                <= 1'b0;
      r_error               <= '0;
    end else begin
      r_memories_preprocess <= w_accept;
      r_result_valid        <= w_capture;
      r_reset_mxv           <= (w_next_state == RUN) || (w_next_state == WAIT);
      r_busy                <= w_next_state != IDLE;
      r_done                <= w_next_state == DONE;
      if (w_start) begin
        r_total        <= bus.i_total_with_additional_A;
        r_issued       <= '0;
        r_result_count <= '0;
        r_error        <= '0;
      end
      if (w_accept) begin
        r_issued <= r_issued + CNT_W'(1);
      end
      if (w_capture) begin
        r_result_data  <= bus.i_mXv1_result;
        r_result_count <= r_result_count + CNT_W'(1);
      end
      if (w_err_overrun) begin
        r_error[ERR_OVERRUN] <= 1'b1;
      end
      if (w_err_early) begin
        r_error[ERR_EARLY_FINISH] <= 1'b1;
      end
    end
  end

  mxv_addr_counter #(
    .AW (AW)
  ) u_addr_counter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_start),
    .i_inc  (w_accept),
    .o_addr (w_addr)
  );

  assign bus.o_memoryA_read_address   = w_addr;
  assign bus.o_col_nos_read_address   = w_addr;
  assign bus.o_multiples_read_address = w_addr;
  assign bus.o_memories_preprocess    = r_memories_preprocess;
  assign bus.o_reset_mXv1             = r_reset_mxv;
  assign bus.o_result_data            = r_result_data;
  assign bus.o_result_valid           = r_result_valid;
  assign bus.o_result_count           = r_result_count;
  assign bus.o_busy                   = r_busy;
  assign bus.o_done                   = r_done;
  assign bus.o_error                  = r_error;

endmodule
